// File: rtl/dt_pack_if.sv
// -----------------------------------------------------------------------------
// dt_pack_if : RAM-side bus bundle for dt_pack.
//   res_rd   : result-RAM read enable
//   res_addr : pixel index {row[6:0], col[6:0]}
//   res_di   : result-RAM read data, valid one cycle after res_addr
//   sti_wr   : image-RAM write strobe, one cycle per packed word
//   sti_addr : word index {row[6:0], colword[2:0]}
//   sti_do   : packed word, bit i = pixel column colword*16+i
// master = packer side, slave = RAM side.
// -----------------------------------------------------------------------------
interface dt_pack_if;
  logic        res_rd;
  logic [13:0] res_addr;
  logic [7:0]  res_di;
  logic        sti_wr;
  logic [9:0]  sti_addr;
  logic [15:0] sti_do;

  modport master (
    output res_rd, res_addr, sti_wr, sti_addr, sti_do,
    input  res_di
  );

  modport slave (
    input  res_rd, res_addr, sti_wr, sti_addr, sti_do,
    output res_di
  );
endinterface

// File: rtl/dt_pack.sv
// -----------------------------------------------------------------------------
// dt_pack : streams a 128x128 8-bit distance map out of the result RAM,
// thresholds each pixel (res_di > thr) and packs 16 pixels per word into a
// 1024 x 16-bit binary image in the image RAM.
//
// Ports:
//   clk        : clock, rising edge
//   reset      : synchronous active-high reset
//   start_i    : one-cycle request, honoured only in IDLE/DONE
//   thr_i      : threshold, latched on an accepted start
//   busy_o     : high from the cycle after an accepted start until done
//   done_o     : high in DONE, cleared by the next accepted start or reset
//   ram        : dt_pack_if.master (result-RAM reads, image-RAM writes)
//   ones_cnt_o : running count of 1 bits written (only with DT_PACK_CNT_EN)
//
// Optional feature macro: DT_PACK_CNT_EN (adds ones_cnt_o and its adder).
// -----------------------------------------------------------------------------
module dt_pack (
  input  logic        clk,
  input  logic        reset,
  input  logic        start_i,
  input  logic [7:0]  thr_i,
  output logic        busy_o,
  output logic        done_o,
  dt_pack_if.master   ram
`ifdef DT_PACK_CNT_EN
  ,
  output logic [14:0] ones_cnt_o
`endif
);

  localparam int STAGES = 1;            // read issue -> data capture
  localparam logic [13:0] LAST_PIX  = 14'h3fff;
  localparam logic [9:0]  LAST_WORD = 10'h3ff;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_e;

  state_e        state_q, state_d;
  logic [7:0]    thr_q;
  logic [13:0]   addr_q;                // pixel being read this cycle
  logic [13:0]   cap_k_q;               // pixel whose data is on res_di
  logic [STAGES:0] vld_pipe;            // [0]: read issued, [1]: data valid
  logic [15:0]   acc_q;                 // word under assembly
  logic          sti_wr_q;
  logic [9:0]    sti_addr_q;
  logic [15:0]   sti_do_q;
  logic          busy_q, done_q;

  logic          accept;
  logic          pix_bit;
  logic          last_wr;

  assign accept  = start_i && (state_q == S_IDLE || state_q == S_DONE);
  assign pix_bit = (ram.res_di > thr_q);
  // The final word sits on the bus this cycle; DRAIN can finish.
  assign last_wr = sti_wr_q && (sti_addr_q == LAST_WORD);

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start_i) state_d = S_RUN;
      S_RUN:   if (addr_q == LAST_PIX) state_d = S_DRAIN;
      S_DRAIN: if (last_wr) state_d = S_DONE;
      S_DONE:  if (start_i) state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Read issue, capture and word packing
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      thr_q      <= '0;
      addr_q     <= '0;
      cap_k_q    <= '0;
      vld_pipe   <= '0;
      acc_q      <= '0;
      sti_wr_q   <= 1'b0;
      sti_addr_q <= '0;
      sti_do_q   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      // data returns one cycle after the address, so the capture stage just
      // follows the issue stage by one register
      vld_pipe[STAGES:1] <= vld_pipe[STAGES-1:0];
      cap_k_q            <= addr_q;
      sti_wr_q           <= 1'b0;

      if (accept) begin
        thr_q       <= thr_i;
        addr_q      <= '0;
        vld_pipe[0] <= 1'b1;
        acc_q       <= '0;
        busy_q      <= 1'b1;
        done_q      <= 1'b0;
      end else if (state_q == S_RUN) begin
        if (addr_q == LAST_PIX) vld_pipe[0] <= 1'b0;
        else                    addr_q      <= addr_q + 14'd1;
      end

      if (vld_pipe[STAGES]) begin
        acc_q[cap_k_q[3:0]] <= pix_bit;
        // last pixel of a word: bypass the accumulator for bit 15 so the word
        // goes out on the very next cycle
        if (cap_k_q[3:0] == 4'hf) begin
          sti_wr_q   <= 1'b1;
          sti_addr_q <= cap_k_q[13:4];
          sti_do_q   <= {pix_bit, acc_q[14:0]};
        end
      end

      if (state_q == S_DRAIN && last_wr) begin
        busy_q <= 1'b0;
        done_q <= 1'b1;
      end
    end
  end

  assign ram.res_rd   = vld_pipe[0];
  assign ram.res_addr = addr_q;
  assign ram.sti_wr   = sti_wr_q;
  assign ram.sti_addr = sti_addr_q;
  assign ram.sti_do   = sti_do_q;
  assign busy_o       = busy_q;
  assign done_o       = done_q;

`ifdef DT_PACK_CNT_EN
  // ---------------------------------------------------------------------------
  // Ones counter: popcount of the word on the bus is folded in at the end of
  // its write cycle, so the total is final on the edge that raises done.
  // ---------------------------------------------------------------------------
  logic [14:0] ones_cnt_q;
  logic [4:0]  word_pop;

  always_comb begin
    word_pop = '0;
    for (int i = 0; i < 16; i++) word_pop = word_pop + {4'd0, sti_do_q[i]};
  end

  always_ff @(posedge clk) begin
    if (reset)         ones_cnt_q <= '0;
    else if (accept)   ones_cnt_q <= '0;
    else if (sti_wr_q) ones_cnt_q <= ones_cnt_q + {10'd0, word_pop};
  end

  assign ones_cnt_o = ones_cnt_q;
`endif

endmodule

// File: tb/tb_dt_pack.sv
module tb_dt_pack;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic [7:0] thr = 8'd0;
  logic       busy, done;
`ifdef DT_PACK_CNT_EN
  logic [14:0] ones_cnt;
`endif

  dt_pack_if ram();

  dt_pack dut (
    .clk     (clk),
    .reset   (reset),
    .start_i (start),
    .thr_i   (thr),
    .busy_o  (busy),
    .done_o  (done),
    .ram     (ram)
`ifdef DT_PACK_CNT_EN
    ,
    .ones_cnt_o (ones_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Result RAM model: synchronous read, one-cycle latency
  logic [7:0] res_mem [16384];
  always @(posedge clk) if (ram.res_rd) ram.res_di <= res_mem[ram.res_addr];

  // Cycle numbering relative to the last accepted start edge E0
  int edge_cnt = 0;
  int start_edge = 0;
  always @(posedge clk) edge_cnt = edge_cnt + 1;
  function automatic int cyc();
    return edge_cnt - start_edge + 1;
  endfunction

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc());
    end
  endtask

  // Scoreboard of expected image-RAM writes
  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;
  exp_t sb[$];

  always @(negedge clk) begin
    if (ram.sti_wr) begin
      exp_t e;
      if (sb.size() == 0) begin
        n_chk++;
        n_err++;
        $display("FAIL spurious_write: got write addr %0d data %0h at cycle %0d, expected none",
                 ram.sti_addr, ram.sti_do, cyc());
      end else begin
        e = sb.pop_front();
        chk("wr_addr", 32'(ram.sti_addr), e.addr);
        chk("wr_data", 32'(ram.sti_do), e.data);
        chk("wr_cycle", cyc(), e.cyc);
      end
    end
  end

  task automatic wait_to(input int n);
    while (cyc() < n) @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_done"}, 32'(done), 0);
    chk({tag, "_res_rd"}, 32'(ram.res_rd), 0);
    chk({tag, "_res_addr"}, 32'(ram.res_addr), 0);
    chk({tag, "_sti_wr"}, 32'(ram.sti_wr), 0);
    chk({tag, "_sti_addr"}, 32'(ram.sti_addr), 0);
    chk({tag, "_sti_do"}, 32'(ram.sti_do), 0);
`ifdef DT_PACK_CNT_EN
    chk({tag, "_ones_cnt"}, 32'(ones_cnt), 0);
`endif
  endtask

  // One pass over res_mem with threshold t.
  // abort != 0: reset is raised during cycle 'abort' and the image abandoned.
  // mid: extra start pulses with a different thr at cycles 5 and 9000.
  task automatic run(input logic [7:0] t, input int abort, input bit mid);
    int expw[1024];
    int total = 0;
    for (int w = 0; w < 1024; w++) begin
      int word = 0;
      for (int i = 0; i < 16; i++)
        if (int'(res_mem[w*16+i]) > int'(t)) word = word | (1 << i);
      expw[w] = word;
      total += $countones(word);
    end
    for (int w = 0; w < 1024; w++)
      if (abort == 0 || 16*w + 18 <= abort)
        sb.push_back('{w, expw[w], 16*w + 18});

    @(negedge clk);
    thr   = t;
    start = 1'b1;
    @(posedge clk);
    #1;
    start_edge = edge_cnt;
    start = 1'b0;
    thr   = ~t;                        // must not matter after the accept
    @(negedge clk);
    chk("c1_busy", 32'(busy), 1);
    chk("c1_done", 32'(done), 0);
    chk("c1_res_rd", 32'(ram.res_rd), 1);
    chk("c1_res_addr", 32'(ram.res_addr), 0);

    if (mid) begin
      wait_to(5);    start = 1'b1; thr = 8'hff;
      wait_to(6);    start = 1'b0;
      wait_to(9000); start = 1'b1; thr = 8'h00;
      wait_to(9001); start = 1'b0;
    end

    if (abort != 0) begin
      wait_to(abort);
      reset = 1'b1;
      wait_to(abort + 1);
      chk_reset_outputs("abort");
      reset = 1'b0;
      repeat (40) @(negedge clk);
      chk("abort_sb_drained", sb.size(), 0);
    end else begin
      wait_to(16384);
      chk("c16384_res_rd", 32'(ram.res_rd), 1);
      chk("c16384_res_addr", 32'(ram.res_addr), 16383);
      @(negedge clk);
      chk("c16385_res_rd", 32'(ram.res_rd), 0);
      while (!done && cyc() < 20000) @(negedge clk);
      chk("done_cycle", cyc(), 16387);
      chk("done_busy", 32'(busy), 0);
      chk("done_flag", 32'(done), 1);
      chk("sb_drained", sb.size(), 0);
`ifdef DT_PACK_CNT_EN
      chk("ones_cnt", 32'(ones_cnt), total);
`endif
      repeat (3) @(negedge clk);
      chk("done_hold", 32'(done), 1);
    end
    sb.delete();
  endtask

  initial begin
    for (int k = 0; k < 16384; k++) res_mem[k] = 8'd0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("rst");
    reset = 1'b0;
    repeat (2) @(negedge clk);

    // all zeros, thr 0 (partial image)
    run(8'd0, 1000, 1'b0);

    // all ones: thr 0 -> 0xFFFF everywhere; thr 1 -> 0x0000
    for (int k = 0; k < 16384; k++) res_mem[k] = 8'd1;
    run(8'd0, 0, 1'b0);
    run(8'd1, 2000, 1'b0);

    // corner pixels, with ignored mid-run starts
    for (int k = 0; k < 16384; k++) res_mem[k] = 8'd0;
    res_mem[0]     = 8'd5;
    res_mem[16383] = 8'd5;
    run(8'd4, 0, 1'b1);

    // ramp, aborted by reset at cycle 500, then a full clean pass
    for (int k = 0; k < 16384; k++) res_mem[k] = 8'(k);
    run(8'd127, 500, 1'b0);
    run(8'd127, 0, 1'b0);

    // random maps, random threshold and thr=255
    for (int k = 0; k < 16384; k++) res_mem[k] = 8'($urandom_range(0, 255));
    run(8'($urandom_range(0, 255)), 3000, 1'b0);
    run(8'd255, 1500, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
